// File: rtl/rcb_port_arb.sv
// rcb_port_arb: shares one RAM port between lookup reads (priority) and host writes with bounded starvation
module rcb_port_arb #(
    parameter int ADDR_WIDTH    = 10,
    parameter int DATA_WIDTH    = 64,
    parameter int RAM_LATENCY   = 2,
    parameter int WR_STARVE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lkup_req_valid,
    output logic                    lkup_req_ready,
    input  logic [ADDR_WIDTH-1:0]   lkup_req_addr,
    output logic                    lkup_rsp_valid,
    output logic [DATA_WIDTH-1:0]   lkup_rsp_data,
    input  logic                    hpb_wr_req,
    input  logic [ADDR_WIDTH-1:0]   hpb_wr_addr,
    input  logic [DATA_WIDTH-1:0]   hpb_wr_data,
    input  logic [DATA_WIDTH/8-1:0] hpb_wr_byte_en,
    output logic                    rcb_wr_done,
    output logic                    ram_en,
    output logic                    ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    output logic [DATA_WIDTH/8-1:0] ram_be,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);
    localparam int SW = $clog2(WR_STARVE_MAX + 1);
    typedef enum logic [1:0] {ARMED, ISSUE, DONE, WAIT_DROP} state_t;
    state_t                 state, state_nx;
    logic [SW-1:0]          starve_cnt;
    logic [RAM_LATENCY-1:0] rd_sr;
    logic                   wr_pending, starved, rd_grant, wr_grant;
    assign wr_pending     = state == ARMED && hpb_wr_req;
    assign starved        = starve_cnt == SW'(WR_STARVE_MAX);
    assign lkup_req_ready = !reset && !(wr_pending && starved);
    assign rd_grant       = lkup_req_valid && lkup_req_ready;
    assign wr_grant       = wr_pending && (!lkup_req_valid || starved);
    assign rcb_wr_done    = state == DONE;
    assign lkup_rsp_data  = lkup_rsp_valid ? ram_rdata : '0;
    // WAIT_DROP swallows a request still held after done so it cannot write twice
    always_comb begin
        state_nx = state;
        case (state)
            ARMED:     state_nx = wr_grant ? ISSUE : ARMED;
            ISSUE:     state_nx = DONE;
            DONE:      state_nx = hpb_wr_req ? WAIT_DROP : ARMED;
            WAIT_DROP: state_nx = hpb_wr_req ? WAIT_DROP : ARMED;
            default:   state_nx = ARMED;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ARMED;
            starve_cnt     <= '0;
            rd_sr          <= '0;
            lkup_rsp_valid <= 1'b0;
            ram_en         <= 1'b0;
            ram_we         <= 1'b0;
            ram_addr       <= '0;
            ram_wdata      <= '0;
            ram_be         <= '0;
        end else begin
            state          <= state_nx;
            starve_cnt     <= (wr_grant || !wr_pending) ? '0 :
                              (rd_grant && !starved) ? starve_cnt + 1'b1 : starve_cnt;
            rd_sr          <= RAM_LATENCY'({rd_sr, rd_grant});
            lkup_rsp_valid <= rd_sr[RAM_LATENCY-1];
            ram_en         <= rd_grant || wr_grant;
            ram_we         <= wr_grant;
            if (wr_grant) begin
                ram_addr  <= hpb_wr_addr;
                ram_wdata <= hpb_wr_data;
                ram_be    <= hpb_wr_byte_en;
            end else if (rd_grant) begin
                ram_addr <= lkup_req_addr;
                ram_be   <= '0;
            end
        end
    end
endmodule

// File: tb/tb_rcb_port_arb.sv
// tb_rcb_port_arb: directed stimulus with queued expectations checked by an output monitor
module tb_rcb_port_arb;
    localparam int AW = 10, DW = 64, L = 2;
    logic clk = 1'b0, reset = 1'b1;
    logic lkup_req_valid = 1'b0, lkup_req_ready;
    logic [AW-1:0] lkup_req_addr = '0;
    logic lkup_rsp_valid;
    logic [DW-1:0] lkup_rsp_data;
    logic hpb_wr_req = 1'b0;
    logic [AW-1:0] hpb_wr_addr = '0;
    logic [DW-1:0] hpb_wr_data = '0;
    logic [7:0] hpb_wr_byte_en = '0;
    logic rcb_wr_done, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic [7:0] ram_be;
    int total = 0, bad = 0, cyc = 0, we_cyc = -100;
    logic done_armed = 1'b0;
    typedef struct {int c; logic [DW-1:0] v;} exp_t;
    exp_t rdq[$], ramq[$], me;
    logic [81:0] wq[$], mw;
    logic [DW-1:0] mem [1024];
    logic [DW-1:0] p1, p2;

    rcb_port_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_LATENCY(L), .WR_STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset),
        .lkup_req_valid(lkup_req_valid), .lkup_req_ready(lkup_req_ready), .lkup_req_addr(lkup_req_addr),
        .lkup_rsp_valid(lkup_rsp_valid), .lkup_rsp_data(lkup_rsp_data),
        .hpb_wr_req(hpb_wr_req), .hpb_wr_addr(hpb_wr_addr), .hpb_wr_data(hpb_wr_data),
        .hpb_wr_byte_en(hpb_wr_byte_en), .rcb_wr_done(rcb_wr_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_be(ram_be), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [7:0] be);
        logic [DW-1:0] r = o;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b+:8] = n[8*b+:8];
        return r;
    endfunction

    // RAM with two cycles of read latency and byte-enabled writes
    initial for (int i = 0; i < 1024; i++) mem[i] = 64'h1111_0000_0000_0000 | 64'(i);
    always @(posedge clk) begin
        p1 <= mem[ram_addr];
        p2 <= p1;
        if (ram_en && ram_we) mem[ram_addr] <= merge(mem[ram_addr], ram_wdata, ram_be);
    end
    assign ram_rdata = p2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (!reset) begin
        if (ram_en && !ram_we) begin
            if (ramq.size() == 0) chk("ram_rd_spurious", 64'(ram_addr), 64'hFFFF);
            else begin
                me = ramq.pop_front();
                chk("ram_rd_cyc", 64'(cyc), 64'(me.c));
                chk("ram_rd_addr", 64'(ram_addr), me.v);
                chk("ram_rd_be", 64'(ram_be), 64'h0);
            end
        end
        if (ram_en && ram_we) begin
            if (wq.size() == 0) chk("ram_wr_spurious", 64'(ram_addr), 64'hFFFF);
            else begin
                mw = wq.pop_front();
                chk("ram_wr_be", 64'(ram_be), 64'(mw[81:74]));
                chk("ram_wr_addr", 64'(ram_addr), 64'(mw[73:64]));
                chk("ram_wr_data", ram_wdata, mw[63:0]);
            end
            done_armed = 1'b1;
            we_cyc = cyc;
        end
        if (lkup_rsp_valid) begin
            if (rdq.size() == 0) chk("rsp_spurious", lkup_rsp_data, 64'hBAD);
            else begin
                me = rdq.pop_front();
                chk("rsp_cyc", 64'(cyc), 64'(me.c));
                chk("rsp_data", lkup_rsp_data, me.v);
            end
        end
        if (rcb_wr_done) begin
            chk("done_after_we", 64'(done_armed), 64'h1);
            chk("done_cyc", 64'(cyc), 64'(we_cyc + 1));
            done_armed = 1'b0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ramq.push_back('{cyc + 1, 64'(a)});
        rdq.push_back('{cyc + 1 + L, d});
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        lkup_req_valid = 1'b1;
        lkup_req_addr = a;
        @(negedge clk);
        while (!lkup_req_ready && n < 20) begin n++; @(negedge clk); end
        chk("rd_ready", 64'(lkup_req_ready), 64'h1);
        if (lkup_req_ready) push_rd(a, d);
        @(posedge clk);
        #1 lkup_req_valid = 1'b0;
    endtask

    task automatic hw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [7:0] be, input int hold);
        int rc, n = 0;
        wq.push_back({be, a, d});
        hpb_wr_req = 1'b1;
        hpb_wr_addr = a;
        hpb_wr_data = d;
        hpb_wr_byte_en = be;
        rc = cyc;
        @(negedge clk);
        while (!rcb_wr_done && n < 40) begin n++; @(negedge clk); end
        chk("wr_done_seen", 64'(rcb_wr_done), 64'h1);
        chk("wr_we_lat", 64'(we_cyc), 64'(rc + 1));
        repeat (hold + 1) @(posedge clk);
        #1 hpb_wr_req = 1'b0;
        step(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int ng, stall;
        logic dn;
        #7;
        chk("rst_ready", 64'(lkup_req_ready), 64'h0);
        chk("rst_ram_en", 64'(ram_en), 64'h0);
        chk("rst_ram_we", 64'(ram_we), 64'h0);
        chk("rst_rsp_valid", 64'(lkup_rsp_valid), 64'h0);
        chk("rst_rsp_data", lkup_rsp_data, 64'h0);
        chk("rst_done", 64'(rcb_wr_done), 64'h0);
        chk("rst_ram_addr", 64'(ram_addr), 64'h0);
        chk("rst_ram_wdata", ram_wdata, 64'h0);
        chk("rst_ram_be", 64'(ram_be), 64'h0);
        step(2);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(lkup_req_ready), 64'h1);
        step(1);
        rd(10'h005, 64'h1111_0000_0000_0005);
        step(5);
        hw(10'h010, 64'hDEADBEEF_00000001, 8'hFF, 0);
        rd(10'h010, 64'hDEADBEEF_00000001);
        rd(10'h001, 64'h1111_0000_0000_0001);
        rd(10'h002, 64'h1111_0000_0000_0002);
        rd(10'h003, 64'h1111_0000_0000_0003);
        step(5);
        // continuous reads against a held write request
        wq.push_back({8'hFF, 10'h030, 64'h0123_4567_89AB_CDEF});
        hpb_wr_req = 1'b1;
        hpb_wr_addr = 10'h030;
        hpb_wr_data = 64'h0123_4567_89AB_CDEF;
        hpb_wr_byte_en = 8'hFF;
        lkup_req_valid = 1'b1;
        lkup_req_addr = 10'h020;
        ng = 0;
        stall = 0;
        dn = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (lkup_req_ready) begin
                push_rd(10'h020, 64'h1111_0000_0000_0020);
                if (stall == 0) ng++;
            end else stall++;
            if (rcb_wr_done) dn = 1'b1;
            step(1);
            if (dn) hpb_wr_req = 1'b0;
        end
        lkup_req_valid = 1'b0;
        chk("starve_grants", 64'(ng), 64'd8);
        chk("starve_stall", 64'(stall), 64'd1);
        chk("starve_done", 64'(dn), 64'h1);
        step(5);
        rd(10'h030, 64'h0123_4567_89AB_CDEF);
        step(4);
        hw(10'h050, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, 10);
        hw(10'h050, 64'h5555_5555_5555_5555, 8'hFF, 0);
        rd(10'h050, 64'h5555_5555_5555_5555);
        step(4);
        hw(10'h040, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0);
        hw(10'h040, 64'h0, 8'h0F, 0);
        rd(10'h040, 64'hFFFFFFFF_00000000);
        step(5);
        // reset while the write is in ISSUE and reads are in flight
        wq.push_back({8'hFF, 10'h060, 64'h7777_7777_7777_7777});
        hpb_wr_req = 1'b1;
        hpb_wr_addr = 10'h060;
        hpb_wr_data = 64'h7777_7777_7777_7777;
        lkup_req_valid = 1'b1;
        lkup_req_addr = 10'h021;
        stall = 0;
        for (int i = 0; i < 12 && stall == 0; i++) begin
            @(negedge clk);
            if (lkup_req_ready) push_rd(10'h021, 64'h1111_0000_0000_0021);
            else stall = 1;
            step(1);
        end
        chk("mid_issue_we", 64'(ram_we), 64'h1);
        chk("mid_inflight", 64'(rdq.size() >= 2), 64'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_ram_en", 64'(ram_en), 64'h0);
        chk("mid_rst_ram_we", 64'(ram_we), 64'h0);
        chk("mid_rst_rsp_valid", 64'(lkup_rsp_valid), 64'h0);
        chk("mid_rst_done", 64'(rcb_wr_done), 64'h0);
        chk("mid_rst_ready", 64'(lkup_req_ready), 64'h0);
        chk("mid_rst_ram_addr", 64'(ram_addr), 64'h0);
        rdq.delete();
        ramq.delete();
        wq.delete();
        done_armed = 1'b0;
        lkup_req_valid = 1'b0;
        hpb_wr_req = 1'b0;
        step(3);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_rst", 64'(lkup_req_ready), 64'h1);
        step(8);
        rd(10'h007, 64'h1111_0000_0000_0007);
        hw(10'h061, 64'hCAFE_0000_0000_BEEF, 8'hFF, 0);
        rd(10'h061, 64'hCAFE_0000_0000_BEEF);
        step(8);
        chk("rdq_empty", 64'(rdq.size()), 64'h0);
        chk("ramq_empty", 64'(ramq.size()), 64'h0);
        chk("wq_empty", 64'(wq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rcb_port_arb.md
# rcb_port_arb

Single-port RAM arbiter inside each RAM control block (symbol, price, volume, order). It shares one RAM port between the strategy lookup path (reads, valid/ready) and host configuration writes arriving on the hpb write interface (level request, done pulse). Reads have priority, and a bounded-starvation counter guarantees host writes complete. Read data returns in order after a fixed pipeline latency.

## Interface
- ADDR_WIDTH, 10, RAM word address width
- DATA_WIDTH, 64, RAM word width; multiple of 8
- RAM_LATENCY, 2, cycles from ram_en (read) to valid ram_rdata; ≥1
- WR_STARVE_MAX, 8, maximum consecutive read grants while a host write is pending; ≥1
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- lkup_req_valid  in  1  lookup read request
- lkup_req_ready  out  1  request accepted when valid&&ready
- lkup_req_addr  in  ADDR_WIDTH  read address
- lkup_rsp_valid  out  1  read data valid, one-cycle pulse per accepted read
- lkup_rsp_data  out  DATA_WIDTH  read data
- hpb_wr_req  in  1  host write request, level, held until rcb_wr_done
- hpb_wr_addr  in  ADDR_WIDTH  write address, stable while hpb_wr_req high
- hpb_wr_data  in  DATA_WIDTH  write data
- hpb_wr_byte_en  in  DATA_WIDTH/8  byte enables
- rcb_wr_done  out  1  one-cycle pulse, write committed to RAM
- ram_en, ram_we  out  1 each  RAM access strobe / write select (registered)
- ram_addr  out  ADDR_WIDTH; ram_wdata  out  DATA_WIDTH; ram_be  out  DATA_WIDTH/8 (registered)
- ram_rdata  in  DATA_WIDTH  RAM read data

## Operation
- Write FSM states: ARMED, ISSUE, DONE, WAIT_DROP. Reset state ARMED.
- wr_pending = (state==ARMED) && hpb_wr_req.
- lkup_req_ready = !(wr_pending && starve_cnt==WR_STARVE_MAX); independent of lkup_req_valid. Low while reset is asserted.
- Read grant: lkup_req_valid && lkup_req_ready.
- Write grant: wr_pending && (!lkup_req_valid || starve_cnt==WR_STARVE_MAX). Read and write grants are never asserted in the same cycle.
- starve_cnt, width $clog2(WR_STARVE_MAX+1):
  - Cleared on write grant and whenever !wr_pending.
  - Otherwise incremented on each read grant, saturating at WR_STARVE_MAX.
- Write grant:
  - Captures hpb_wr_addr, hpb_wr_data and hpb_wr_byte_en into ram_* and drives ram_en=ram_we=1.
  - FSM moves ARMED→ISSUE.
- FSM transitions:
  - ISSUE→DONE unconditionally.
  - In DONE, rcb_wr_done=1. DONE→ARMED if hpb_wr_req=0, else →WAIT_DROP.
  - WAIT_DROP→ARMED when hpb_wr_req=0. One request therefore yields exactly one RAM write, even if the host holds the request after done.
- Read grant: ram_en=1, ram_we=0, ram_addr=lkup_req_addr, ram_be=0. A valid bit enters a RAM_LATENCY-deep shift register.
- No grant: ram_en=ram_we=0; ram_addr/wdata/be hold their previous values.
- Ordering: reads granted after a write grant observe the new data. Reads granted before it observe the old data.
- Host field changes while hpb_wr_req is high and before the grant are legal. Values are sampled at grant only.

## Timing
- Reset values: lkup_rsp_valid=0, lkup_rsp_data=0, rcb_wr_done=0, ram_en=ram_we=0, ram_addr/wdata/be=0, starve_cnt=0, shift register cleared, FSM=ARMED.
- Read handshake in cycle T: ram_en high in T+1, lkup_rsp_valid and lkup_rsp_data (=ram_rdata) in T+1+RAM_LATENCY.
- Read throughput is one read per cycle when no write is pending.
- Write granted in cycle T: ram_we high in T+1, rcb_wr_done high in T+2. The earliest next write grant is T+3 if hpb_wr_req dropped in T+2.
- Worst-case write latency from hpb_wr_req rise to grant is WR_STARVE_MAX+1 cycles under continuous reads.
- Reset asserted mid-operation:
  - In-flight read responses are discarded (no lkup_rsp_valid).
  - A pending rcb_wr_done is lost. A write already driven on ram_we may have committed.
  - The host must reissue after reset.
- Simultaneous lookup valid and newly rising hpb_wr_req with starve_cnt=0: the read wins.

## Test plan
- Reset, then one read to addr 0x005 in cycle T: ram_en=1/ram_we=0 at T+1; lkup_rsp_valid with RAM content at T+3 (RAM_LATENCY=2). No other response pulses.
- Host write addr 0x010, data 0xDEADBEEF_00000001, byte_en 0xFF, with no reads: ram_we at T+1, rcb_wr_done single pulse at T+2. A following read of 0x010 returns the new data.
- Continuous lkup_req_valid plus a held hpb_wr_req: exactly 8 read grants, then lkup_req_ready=0 for one cycle and the write is granted. Reads resume, and rcb_wr_done pulses once.
- hpb_wr_req held high for 10 cycles after rcb_wr_done: no second ram_we. After the drop and a re-raise, a second write occurs.
- byte_en 0x0F over existing 0xFFFFFFFF_FFFFFFFF with data 0: ram_be=0x0F. A subsequent read returns 0xFFFFFFFF_00000000.
- Async reset pulsed while 2 reads are in flight and the FSM is in ISSUE: outputs go to 0 immediately, no lkup_rsp_valid or rcb_wr_done afterward, and lkup_req_ready returns to 1 after release.
